// File: rtl/partial_sum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM encoding and
// saturation limits for a signed accumulator of a given width.
package partial_sum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/partial_sum_accumulator_sat_add.sv
// Combinational saturating add: signed accumulator plus sign-extended term,
// clamped to the accumulator range, with an overflow flag.
module partial_sum_accumulator_sat_add
  import partial_sum_accumulator_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [IN_W-1:0]  term,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic signed [ACC_W:0] MAX_W = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN_W = (ACC_W+1)'(sat_min(ACC_W));

  logic signed [ACC_W:0] wide;

  function automatic logic signed [ACC_W-1:0] clip(input logic signed [ACC_W:0] v);
    if (v > MAX_W) return MAX_W[ACC_W-1:0];
    if (v < MIN_W) return MIN_W[ACC_W-1:0];
    return v[ACC_W-1:0];
  endfunction

  // One guard bit is enough: |term| < |acc range| since ACC_W > IN_W.
  always_comb begin
    wide = $signed({acc[ACC_W-1], acc})
         + $signed({{(ACC_W+1-IN_W){term[IN_W-1]}}, term});
    ovf  = (wide > MAX_W) || (wide < MIN_W);
    sum  = clip(wide);
  end

endmodule

// File: rtl/partial_sum_accumulator.sv
// Accumulates NUM_TERMS signed terms into a saturating register and hands the
// total off on a valid/ready port; supports back-to-back restarts from DONE.
module partial_sum_accumulator
  import partial_sum_accumulator_pkg::*;
#(
  parameter int IN_W      = 11,
  parameter int ACC_W     = 16,
  parameter int NUM_TERMS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    busy
);

  localparam int CNT_W = $clog2(NUM_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] out_data_q;
  logic                    out_sat_q;
  logic                    clr, take, last;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;

  partial_sum_accumulator_sat_add #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_sat_add (
    .acc (acc_q),
    .term(in_data),
    .sum (sum),
    .ovf (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    take    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          take = 1'b1;
          if (cnt_q == LAST_CNT) begin
            last    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // A start coinciding with the handshake skips the IDLE bubble.
        if (out_ready) begin
          if (start) begin
            clr     = 1'b1;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (clr) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      out_sat_q <= 1'b0;
    end else if (take) begin
      acc_q <= sum;
      cnt_q <= cnt_q + CNT_W'(1);
      if (ovf)  out_sat_q  <= 1'b1;
      if (last) out_data_q <= sum;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM) || (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Bench for partial_sum_accumulator: three configurations (default, ACC_W=12,
// NUM_TERMS=1) exercised one at a time against a transaction-level model.
module tb_partial_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic              in_valid;
  logic signed [10:0] in_data;
  logic              out_ready;
  logic [1:0]        sel;
  logic [2:0]        start_v;
  logic [2:0]        in_ready_v, out_valid_v, out_sat_v, busy_v;
  logic signed [15:0] d0, d2;
  logic signed [11:0] d1;

  logic              obs_in_ready, obs_out_valid, obs_sat, obs_busy;
  logic signed [15:0] obs_data;

  int n_cmp = 0;
  int n_bad = 0;

  longint m_acc;
  bit     m_sat;

  assign start_v = start ? (3'b001 << sel) : 3'b000;

  partial_sum_accumulator #(.IN_W(11), .ACC_W(16), .NUM_TERMS(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .in_data(in_data), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_data(d0), .out_sat(out_sat_v[0]), .busy(busy_v[0]));

  partial_sum_accumulator #(.IN_W(11), .ACC_W(12), .NUM_TERMS(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .in_data(in_data), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_data(d1), .out_sat(out_sat_v[1]), .busy(busy_v[1]));

  partial_sum_accumulator #(.IN_W(11), .ACC_W(16), .NUM_TERMS(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid),
    .in_ready(in_ready_v[2]), .in_data(in_data), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_data(d2), .out_sat(out_sat_v[2]), .busy(busy_v[2]));

  assign obs_in_ready  = in_ready_v[sel];
  assign obs_out_valid = out_valid_v[sel];
  assign obs_sat       = out_sat_v[sel];
  assign obs_busy      = busy_v[sel];
  assign obs_data      = (sel == 2'd1) ? {{4{d1[11]}}, d1} : ((sel == 2'd2) ? d2 : d0);

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic int nterms();
    return (sel == 2'd2) ? 1 : 4;
  endfunction

  function automatic int accw();
    return (sel == 2'd1) ? 12 : 16;
  endfunction

  // Reference: exact sum clamped to the signed accumulator range after every term.
  task automatic model_add(input int t);
    longint mx = (64'sd1 <<< (accw() - 1)) - 1;
    longint mn = -(64'sd1 <<< (accw() - 1));
    longint s  = m_acc + t;
    if (s > mx) begin s = mx; m_sat = 1'b1; end
    else if (s < mn) begin s = mn; m_sat = 1'b1; end
    m_acc = s;
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_sat = 1'b0;
  endtask

  task automatic begin_txn();
    repeat ($urandom_range(0, 2)) begin
      start = 1'b0; in_valid = 1'($urandom_range(0, 1)); in_data = 11'($urandom);
      @(negedge clk);
      chk("idle_busy", obs_busy, 0);
    end
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_ready", obs_in_ready, 1);
    chk("start_busy", obs_busy, 1);
    chk("start_sat_clr", obs_sat, 0);
    model_clear();
  endtask

  task automatic feed(input int q[$]);
    foreach (q[i]) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = 11'($urandom); start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk("accum_in_ready", obs_in_ready, 1);
      chk("accum_out_valid", obs_out_valid, 0);
      in_valid = 1'b1; in_data = 11'(q[i]); start = 1'($urandom_range(0, 1));
      @(negedge clk);
      model_add(q[i]);
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_done();
    chk("done_valid", obs_out_valid, 1);
    chk("done_in_ready", obs_in_ready, 0);
    chk("done_busy", obs_busy, 1);
    chk("done_data", obs_data, m_acc);
    chk("done_sat", obs_sat, m_sat);
  endtask

  task automatic finish_txn(input int hold, input bit b2b);
    repeat (hold) begin
      out_ready = 1'b0; start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1)); in_data = 11'($urandom);
      @(negedge clk);
      chk("hold_valid", obs_out_valid, 1);
      chk("hold_data", obs_data, m_acc);
      chk("hold_sat", obs_sat, m_sat);
      chk("hold_in_ready", obs_in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = b2b;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    if (b2b) begin
      chk("b2b_in_ready", obs_in_ready, 1);
      chk("b2b_busy", obs_busy, 1);
      chk("b2b_valid", obs_out_valid, 0);
      chk("b2b_sat_clr", obs_sat, 0);
      model_clear();
    end else begin
      chk("ret_busy", obs_busy, 0);
      chk("ret_valid", obs_out_valid, 0);
      chk("ret_in_ready", obs_in_ready, 0);
      chk("ret_data", obs_data, m_acc);
    end
  endtask

  initial begin
    int q[$];
    bit in_accum;
    bit b2b;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel = 2'd0;
    m_acc = 0; m_sat = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_valid", obs_out_valid, 0);
      chk("rst_in_ready", obs_in_ready, 0);
      chk("rst_busy", obs_busy, 0);
      chk("rst_data", obs_data, 0);
      chk("rst_sat", obs_sat, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 2'd0;

    // Asynchronous reset in the middle of an accumulation.
    begin_txn();
    q = {5, 6};
    feed(q);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", obs_out_valid, 0);
    chk("arst_in_ready", obs_in_ready, 0);
    chk("arst_busy", obs_busy, 0);
    chk("arst_data", obs_data, 0);
    @(negedge clk);
    rst = 1'b0;
    begin_txn();
    q = {1, 1, 1, 1};
    feed(q);
    check_done();
    chk("t1_sum", obs_data, 4);
    chk("t1_sat", obs_sat, 0);
    finish_txn(1, 1'b0);

    // Mixed-sign terms with gaps, then a long stall in DONE.
    begin_txn();
    q = {100, -50, 300, -1};
    feed(q);
    check_done();
    chk("t2_sum", obs_data, 349);
    finish_txn(5, 1'b1);

    // Back-to-back result must not include the previous total.
    q = {7, 8, 9, 10};
    feed(q);
    check_done();
    chk("t5_sum", obs_data, 34);
    finish_txn(0, 1'b0);

    // Saturation in the 12-bit configuration.
    sel = 2'd1;
    begin_txn();
    q = {1023, 1023, 1023, 1023};
    feed(q);
    check_done();
    chk("t3_pos", obs_data, 2047);
    chk("t3_pos_sat", obs_sat, 1);
    finish_txn(1, 1'b1);
    q = {-1024, -1024, -1024, -1024};
    feed(q);
    check_done();
    chk("t3_neg", obs_data, -2048);
    chk("t3_neg_sat", obs_sat, 1);
    finish_txn(0, 1'b0);

    // Single-term configuration.
    sel = 2'd2;
    begin_txn();
    q = {-7};
    feed(q);
    check_done();
    chk("t6_sum", obs_data, -7);
    finish_txn(2, 1'b0);

    // Randomized transactions across all configurations.
    in_accum = 1'b0;
    for (int it = 0; it < 30; it++) begin
      int pat;
      if (!in_accum) begin
        sel = 2'($urandom_range(0, 2));
        begin_txn();
      end
      pat = $urandom_range(0, 3);
      q = {};
      for (int k = 0; k < nterms(); k++) begin
        case (pat)
          0:       q.push_back(int'($urandom_range(0, 2047)) - 1024);
          1:       q.push_back(int'($urandom_range(0, 40)) - 20);
          2:       q.push_back(($urandom_range(0, 1) != 0) ? 1023 : -1024);
          default: q.push_back(int'($urandom_range(900, 1023)));
        endcase
      end
      feed(q);
      check_done();
      b2b = (it == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      finish_txn($urandom_range(0, 3), b2b);
      in_accum = b2b;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
